jtframe_i2s_rx: RTL and testbench



---
 rtl/jtframe_i2s_pkg.sv | 17 +
 rtl/jtframe_i2s_rx_sync.sv | 31 +++
 rtl/jtframe_i2s_rx.sv | 145 ++++++++++++++
 tb/tb_jtframe_i2s_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/jtframe_i2s_pkg.sv
// rtl/jtframe_i2s_pkg.sv - shared types and constants for the I2S receiver
package jtframe_i2s_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUN
  } state_t;

  typedef enum logic {
    FMT_PHILIPS = 1'b0,
    FMT_LJ      = 1'b1
  } fmt_t;

endpackage

// File: rtl/jtframe_i2s_rx_sync.sv
// rtl/jtframe_i2s_rx_sync.sv - 2-FF synchroniser for the I2S pins plus bit-clock rise detector
module jtframe_i2s_rx_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:1] dout,
  output logic         rise
);

  logic [W-1:0] s1, s2, s3;

  // bit 0 is the bit clock; s3 keeps the data aligned with the registered rise
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2[0] & ~s3[0];
    end
  end

  assign dout = s3[W-1:1];

endmodule

// File: rtl/jtframe_i2s_rx.sv
// rtl/jtframe_i2s_rx.sv - I2S receiver deserialising L/R slots into parallel samples
// Left-justified decoding is built only when JTFRAME_I2S_RX_LJ_EN is defined.
module jtframe_i2s_rx
  import jtframe_i2s_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter logic SIGNED_SND = 1'b1,
  parameter int   TO_BITS    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdin,
  input  logic             fmt_lj,
  output logic [WIDTH-1:0] snd_left,
  output logic [WIDTH-1:0] snd_right,
  output logic             sample_valid,
  output logic             locked
);

  logic [2:1]         sync_q;
  logic               rise, lr, sd, lr_d, lr_chg;
  state_t             state;
  logic [CNT_W-1:0]   cnt, cnt_inc, next_cnt;
  logic [WIDTH-1:0]   sr, sr_shift, next_sr, close_val, left_hold;
  logic [TO_BITS-1:0] wd;
  logic               wd_arm;

  jtframe_i2s_rx_sync #(.W(3)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({sdin, lrclk, sclk}),
    .dout (sync_q),
    .rise (rise)
  );

  assign lr     = sync_q[1];
  assign sd     = sync_q[2];
  assign lr_chg = lr != lr_d;

`ifdef JTFRAME_I2S_RX_LJ_EN
  fmt_t fmt;
`else
  logic fmt_unused;
  assign fmt_unused = fmt_lj;
`endif

  // left-align a slot of n received bits, zero padding short slots
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] n);
    logic [WIDTH-1:0] r;
    if (int'(n) < WIDTH) r = v << (WIDTH - int'(n));
    else                 r = v;
    if (!SIGNED_SND) r[WIDTH-1] = ~r[WIDTH-1];
    return r;
  endfunction

  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign sr_shift = (int'(cnt) < WIDTH) ? {sr[WIDTH-2:0], sd} : sr;

  always_comb begin
    next_sr   = sr_shift;
    next_cnt  = cnt_inc;
    close_val = align(sr_shift, cnt_inc);
    if (lr_chg) begin
`ifdef JTFRAME_I2S_RX_LJ_EN
      if (fmt == FMT_LJ) begin
        // old slot closes without this bit; it starts the new channel
        close_val = align(sr, cnt);
        next_sr   = {{(WIDTH-1){1'b0}}, sd};
        next_cnt  = CNT_W'(1);
      end else begin
        next_sr  = '0;
        next_cnt = '0;
      end
`else
      next_sr  = '0;
      next_cnt = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sr           <= '0;
      left_hold    <= '0;
      lr_d         <= 1'b0;
      snd_left     <= '0;
      snd_right    <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      wd           <= '0;
      wd_arm       <= 1'b0;
`ifdef JTFRAME_I2S_RX_LJ_EN
      fmt          <= FMT_PHILIPS;
`endif
    end else begin
      sample_valid <= 1'b0;
`ifdef JTFRAME_I2S_RX_LJ_EN
      if (state == ST_IDLE) fmt <= fmt_lj ? FMT_LJ : FMT_PHILIPS;
`endif
      if (rise) begin
        wd     <= '0;
        wd_arm <= 1'b1;
        lr_d   <= lr;
        if (state == ST_IDLE) begin
          if (lr_chg) begin
            state <= ST_SYNC;
            sr    <= next_sr;
            cnt   <= next_cnt;
          end
        end else begin
          sr  <= next_sr;
          cnt <= next_cnt;
          if (lr_chg) begin
            if (!lr_d) begin
              left_hold <= close_val;
            end else if (state == ST_RUN) begin
              snd_left     <= left_hold;
              snd_right    <= close_val;
              sample_valid <= 1'b1;
            end else begin
              // first right close only proves alignment; left_hold may be stale
              locked <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end
      end else if (wd_arm) begin
        if (wd == '1) begin
          state  <= ST_IDLE;
          locked <= 1'b0;
          cnt    <= '0;
          wd     <= '0;
          wd_arm <= 1'b0;
        end else begin
          wd <= wd + TO_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_i2s_rx.sv
// tb/tb_jtframe_i2s_rx.sv - scoreboard bench for jtframe_i2s_rx, signed and unsigned instances side by side
module tb_jtframe_i2s_rx;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, lrclk = 1'b0, sdin = 1'b0, fmt_lj = 1'b0;
  logic [15:0] sl_s, sr_s, sl_u, sr_u;
  logic sv_s, sv_u, lk_s, lk_u;
  logic allow_change = 1'b0;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  pair_t exp_q[$];
  pair_t last_exp;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jtframe_i2s_rx #(.WIDTH(16), .SIGNED_SND(1'b1), .TO_BITS(10)) dut_s (
    .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdin(sdin), .fmt_lj(fmt_lj),
    .snd_left(sl_s), .snd_right(sr_s), .sample_valid(sv_s), .locked(lk_s)
  );

  jtframe_i2s_rx #(.WIDTH(16), .SIGNED_SND(1'b0), .TO_BITS(10)) dut_u (
    .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdin(sdin), .fmt_lj(fmt_lj),
    .snd_left(sl_u), .snd_right(sr_u), .sample_valid(sv_u), .locked(lk_u)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // one bit: data/word-select change while SCLK is low, SCLK = clk/8
  task automatic send_bit(input logic lr, input logic d);
    sclk  = 1'b0;
    lrclk = lr;
    sdin  = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Philips: word select flips on the LSB; LJ: word select constant across the slot
  task automatic send_bits(input logic [31:0] v, input int hi, input int lo, input logic lr_body, input logic lj);
    for (int i = hi; i >= lo; i--)
      send_bit((lj || i != 0) ? lr_body : ~lr_body, v[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input logic lj);
    send_bits(l, n-1, 0, 1'b0, lj);
    send_bits(r, n-1, 0, 1'b1, lj);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
    last_exp = {l, r};
  endtask

  task automatic pulse_reset();
    allow_change = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    allow_change = 1'b0;
  endtask

  // monitor: pops expectations on sample_valid, flags output changes without it
  initial begin
    pair_t e;
    logic [63:0] prev, cur;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {sl_s, sr_s, sl_u, sr_u};
      if (sv_s || sv_u) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got valid %b/%b, expected none (L=%h R=%h)", sv_s, sv_u, sl_s, sr_s);
        end else begin
          e = exp_q.pop_front();
          check("valid_s", {31'd0, sv_s}, 32'd1);
          check("valid_u", {31'd0, sv_u}, 32'd1);
          check("left_s", {16'd0, sl_s}, {16'd0, e.l});
          check("right_s", {16'd0, sr_s}, {16'd0, e.r});
          check("left_u", {16'd0, sl_u}, {16'd0, e.l ^ 16'h8000});
          check("right_u", {16'd0, sr_u}, {16'd0, e.r ^ 16'h8000});
        end
      end
      if (!allow_change && cur != prev)
        check("change_needs_valid", {30'd0, sv_s, sv_u}, 32'd3);
      prev = cur;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_left_s", {16'd0, sl_s}, 32'd0);
    check("reset_right_s", {16'd0, sr_s}, 32'd0);
    check("reset_left_u", {16'd0, sl_u}, 32'd0);
    check("reset_right_u", {16'd0, sr_u}, 32'd0);
    check("reset_valid", {30'd0, sv_s, sv_u}, 32'd0);
    check("reset_locked", {30'd0, lk_s, lk_u}, 32'd0);

    // Philips 16-bit: first frame only locks
    send_frame(32'h8001, 32'h7FFE, 16, 1'b0);
    repeat (2) @(negedge clk);
    check("lock_first_frame", {30'd0, lk_s, lk_u}, 32'd3);
    repeat (2) begin
      expect_pair(16'h8001, 16'h7FFE);
      send_frame(32'h8001, 32'h7FFE, 16, 1'b0);
    end

    // 32-bit slots truncated to the first 16 bits
    repeat (2) begin
      expect_pair(16'h1234, 16'hFFFF);
      send_frame(32'h1234_ABCD, 32'hFFFF_0000, 32, 1'b0);
    end

    // 12-bit slots, zero padded
    repeat (2) begin
      expect_pair(16'h8000, 16'h0010);
      send_frame(32'h800, 32'h001, 12, 1'b0);
    end

    // 1-bit slots
    repeat (2) begin
      expect_pair(16'h8000, 16'h0000);
      send_frame(32'h1, 32'h0, 1, 1'b0);
    end

    // SCLK stops long enough for the watchdog
    repeat (1100) @(negedge clk);
    check("timeout_unlock", {30'd0, lk_s, lk_u}, 32'd0);
    check("hold_left_s", {16'd0, sl_s}, {16'd0, last_exp.l});
    check("hold_right_s", {16'd0, sr_s}, {16'd0, last_exp.r});
    check("hold_left_u", {16'd0, sl_u}, {16'd0, last_exp.l ^ 16'h8000});
    check("hold_right_u", {16'd0, sr_u}, {16'd0, last_exp.r ^ 16'h8000});
    send_frame(32'h8001, 32'h7FFE, 16, 1'b0);
    repeat (2) @(negedge clk);
    check("relock", {30'd0, lk_s, lk_u}, 32'd3);
    repeat (2) begin
      expect_pair(16'h0F0F, 16'hF0F0);
      send_frame(32'h0F0F, 32'hF0F0, 16, 1'b0);
    end

    // reset halfway through a left slot
    send_bits(32'hC3A5, 15, 8, 1'b0, 1'b0);
    pulse_reset();
    check("midreset_left", {sl_s, sl_u}, 32'd0);
    check("midreset_right", {sr_s, sr_u}, 32'd0);
    check("midreset_locked", {30'd0, lk_s, lk_u}, 32'd0);
    send_bits(32'hC3A5, 7, 0, 1'b0, 1'b0);
    send_bits(32'h5A3C, 15, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("midreset_relock", {30'd0, lk_s, lk_u}, 32'd3);
    expect_pair(16'hC3A5, 16'h5A3C);
    send_frame(32'hC3A5, 32'h5A3C, 16, 1'b0);

    // left-justified stimulus, closed by one trailing left bit of 0
    fmt_lj = 1'b1;
    pulse_reset();
    send_frame(32'hA5A5, 32'h5A5A, 16, 1'b1);
`ifdef JTFRAME_I2S_RX_LJ_EN
    expect_pair(16'hA5A5, 16'h5A5A);
    send_frame(32'hA5A5, 32'h5A5A, 16, 1'b1);
    expect_pair(16'hA5A5, 16'h5A5A);
    send_frame(32'hA5A5, 32'h5A5A, 16, 1'b1);
`else
    expect_pair(16'h4B4A, 16'hB4B5);
    send_frame(32'hA5A5, 32'h5A5A, 16, 1'b1);
    expect_pair(16'h4B4A, 16'hB4B4);
    send_frame(32'hA5A5, 32'h5A5A, 16, 1'b1);
`endif
    send_bit(1'b0, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
